// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide unit.
package mdu_pkg;

    localparam int ITER_DEF = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // |0x80000000| stays 0x80000000 when read as unsigned
    function automatic logic [31:0] mag32(input logic [31:0] x,
                                          input logic sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring divide core on magnitudes; one quotient bit per enabled step.
module mdu_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_step,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_quot,
    output logic [W-1:0] o_rem
);

    logic [W-1:0] r_rem;
    logic [W-1:0] r_quo;
    logic [W-1:0] r_dvs;
    logic [W:0]   w_sh;
    logic [W:0]   w_diff;

    assign w_sh   = {r_rem, r_quo[W-1]};
    assign w_diff = w_sh - {1'b0, r_dvs};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
        end else if (i_step) begin
            if (!w_diff[W]) begin
                r_rem <= w_diff[W-1:0];
                r_quo <= {r_quo[W-2:0], 1'b1};
            end else begin
                r_rem <= w_sh[W-1:0];
                r_quo <= {r_quo[W-2:0], 1'b0};
            end
        end
    end

    assign o_quot = r_quo;
    assign o_rem  = r_rem;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/DIV unit with HI/LO registers and busy/done handshake.
// Define MDU_DIV_EN to build the divider and enable DIV/DIVU.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int ITER = ITER_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_prod;
    logic [31:0]   r_mcand;
    logic          r_neg;
    logic          r_busy;
    logic          r_done;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    logic        w_signed;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_idle_ok;
    logic        w_issue;
    logic        w_last;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_sum;
    logic [63:0] w_prod_nx;
    logic [63:0] w_prod_fix;
    logic [31:0] w_hi_res;
    logic [31:0] w_lo_res;

    assign w_signed  = (op == OP_MULT) || (op == OP_DIV);
    assign w_is_mul  = (op == OP_MULT) || (op == OP_MULTU);
    assign w_idle_ok = (r_state == ST_IDLE) && start && !flush;
    assign w_issue   = w_idle_ok && (w_is_mul || w_is_div);
    assign w_last    = (r_cnt == CW'(ITER - 1));
    assign w_mag_a   = mag32(rs_data, w_signed);
    assign w_mag_b   = mag32(rt_data, w_signed);

    // Shift-add: upper half accumulates, multiplier drains out the bottom
    assign w_sum      = {1'b0, r_prod[63:32]}
                      + (r_prod[0] ? {1'b0, r_mcand} : 33'd0);
    assign w_prod_nx  = {w_sum, r_prod[31:1]};
    assign w_prod_fix = r_neg ? (~r_prod + 64'd1) : r_prod;

`ifdef MDU_DIV_EN
    logic        r_is_div;
    logic        r_rneg;
    logic        r_dzero;
    logic [31:0] r_a;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_div <= 1'b0;
            r_rneg   <= 1'b0;
            r_dzero  <= 1'b0;
            r_a      <= '0;
        end else if (w_issue) begin
            r_is_div <= w_is_div;
            r_rneg   <= (op == OP_DIV) && rs_data[31];
            r_dzero  <= (rt_data == 32'd0);
            r_a      <= rs_data;
        end
    end

    mdu_divider #(.W(32)) u_div (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_issue && w_is_div),
        .i_step     ((r_state == ST_CALC) && r_is_div),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    always_comb begin
        w_hi_res = w_prod_fix[63:32];
        w_lo_res = w_prod_fix[31:0];
        if (r_is_div) begin
            if (r_dzero) begin
                w_hi_res = r_a;
                w_lo_res = 32'hFFFF_FFFF;
            end else begin
                w_lo_res = r_neg  ? (~w_quot + 32'd1) : w_quot;
                w_hi_res = r_rneg ? (~w_rem + 32'd1)  : w_rem;
            end
        end
    end
`else
    assign w_is_div = 1'b0;

    always_comb begin
        w_hi_res = w_prod_fix[63:32];
        w_lo_res = w_prod_fix[31:0];
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_prod  <= '0;
            r_mcand <= '0;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_state <= ST_CALC;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_prod  <= {32'd0, w_mag_a};
                        r_mcand <= w_mag_b;
                        r_neg   <= w_signed && (rs_data[31] ^ rt_data[31]);
                    end else if (w_idle_ok && op == OP_MTHI) begin
                        r_hi <= rs_data;
                    end else if (w_idle_ok && op == OP_MTLO) begin
                        r_lo <= rs_data;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_prod <= w_prod_nx;
                        r_cnt  <= r_cnt + 1'b1;
                        if (w_last) r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (!flush) begin
                        r_hi   <= w_hi_res;
                        r_lo   <= w_lo_res;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: vector table, corner sequences, random ops.
module tb_mdu_hilo;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_err = 0;
    int n_chk = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mdu_hilo dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    typedef struct {
        string       nm;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
    } tv_t;

    tv_t tbl[$];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bit is_long(input logic [2:0] o);
`ifdef MDU_DIV_EN
        return o <= 3'b011;
`else
        return o <= 3'b001;
`endif
    endfunction

    // Reference: plain signed/unsigned arithmetic on the architectural rules
    function automatic void model(input logic [2:0] o, input logic [31:0] a,
                                  input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l);
        longint      p;
        logic [63:0] u;
        case (o)
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {h, l} = p;
            end
            OP_MULTU: begin
                u = {32'd0, a} * {32'd0, b};
                {h, l} = u;
            end
            OP_DIV, OP_DIVU: begin
                if (is_long(o)) begin
                    if (b == 32'd0) begin
                        h = a;
                        l = 32'hFFFF_FFFF;
                    end else if (o == OP_DIV) begin
                        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                            l = 32'h8000_0000;
                            h = 32'd0;
                        end else begin
                            l = $signed(a) / $signed(b);
                            h = $signed(a) % $signed(b);
                        end
                    end else begin
                        l = a / b;
                        h = a % b;
                    end
                end
            end
            OP_MTHI: h = a;
            OP_MTLO: l = a;
            default: ;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int from, input string nm, output int at);
        int cyc;
        bit seen;
        bit bz;
        cyc = from;
        seen = 1'b0;
        bz = 1'b1;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else if (!busy) bz = 1'b0;
        end
        at = cyc;
        check({nm, " latency"}, 64'(cyc), 64'd33);
        check({nm, " busy held"}, 64'(bz), 64'd1);
    endtask

    task automatic run_op(input string nm, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_hi, input logic [31:0] e_lo);
        int at;
        bit lng;
        bit any;
        lng = is_long(o);
        issue(o, a, b);
        check({nm, " busy rise"}, 64'(busy), 64'(lng));
        if (lng) begin
            wait_done(0, nm, at);
            check({nm, " hi"}, 64'(hi), 64'(e_hi));
            check({nm, " lo"}, 64'(lo), 64'(e_lo));
            @(negedge clk);
            check({nm, " done pulse"}, {62'd0, busy, done}, 64'd0);
        end else begin
            check({nm, " hi"}, 64'(hi), 64'(e_hi));
            check({nm, " lo"}, 64'(lo), 64'(e_lo));
            any = done;
            repeat (3) begin
                @(negedge clk);
                any = any | busy | done;
            end
            check({nm, " quiet"}, 64'(any), 64'd0);
        end
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int at;
        bit any;
        logic [2:0] o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;

        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = 3'b000;
        rs_data = '0;
        rt_data = '0;

        tbl.push_back('{"mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3,
                        32'hFFFF_FFFF, 32'hFFFF_FFFA});
        tbl.push_back('{"multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3,
                        32'h0000_0002, 32'hFFFF_FFFA});
        tbl.push_back('{"mthi", OP_MTHI, 32'hDEAD_BEEF, 32'd0,
                        32'hDEAD_BEEF, 32'hFFFF_FFFA});
        tbl.push_back('{"mtlo", OP_MTLO, 32'h0000_1234, 32'd0,
                        32'hDEAD_BEEF, 32'h0000_1234});
        tbl.push_back('{"undef_op", 3'b110, 32'h55, 32'h66,
                        32'hDEAD_BEEF, 32'h0000_1234});
        tbl.push_back('{"mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000,
                        32'h4000_0000, 32'h0000_0000});
        tbl.push_back('{"multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                        32'hFFFF_FFFE, 32'h0000_0001});
`ifdef MDU_DIV_EN
        tbl.push_back('{"div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2,
                        32'hFFFF_FFFF, 32'hFFFF_FFFD});
        tbl.push_back('{"divu_zero", OP_DIVU, 32'd7, 32'd0,
                        32'h0000_0007, 32'hFFFF_FFFF});
        tbl.push_back('{"div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                        32'h0000_0000, 32'h8000_0000});
        tbl.push_back('{"divu", OP_DIVU, 32'd100, 32'd7,
                        32'h0000_0002, 32'h0000_000E});
`else
        tbl.push_back('{"divu_off", OP_DIVU, 32'd10, 32'd3,
                        32'hFFFF_FFFE, 32'h0000_0001});
`endif

        repeat (2) @(negedge clk);
        check("reset state", {hi, lo}, 64'd0);
        check("reset flags", {62'd0, busy, done}, 64'd0);
        reset = 1'b0;

        foreach (tbl[i])
            run_op(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].e_hi, tbl[i].e_lo);

        // Flush mid-CALC: result discarded, no done
        run_op("mtlo_pre", OP_MTLO, 32'h1234, 32'd0, m_hi, 32'h1234);
        issue(OP_MULT, 32'd5, 32'd5);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush hilo", {hi, lo}, {m_hi, 32'h1234});
        any = 1'b0;
        repeat (35) begin
            @(negedge clk);
            any = any | done | busy;
        end
        check("flush no done", 64'(any), 64'd0);

        // Flush in IDLE drops both a MULT and an MTHI
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b1;
            flush = 1'b1;
            op = (k == 0) ? OP_MULT : OP_MTHI;
            rs_data = 32'd77;
            rt_data = 32'd9;
            @(negedge clk);
            start = 1'b0;
            flush = 1'b0;
            any = busy;
            repeat (35) begin
                @(negedge clk);
                any = any | done | busy;
            end
            check("idle flush quiet", 64'(any), 64'd0);
            check("idle flush hilo", {hi, lo}, {m_hi, m_lo});
        end

        // Start while busy is ignored
        a = 32'h1234_5678;
        b = 32'hFFFF_0000;
        eh = m_hi;
        el = m_lo;
        model(OP_MULT, a, b, eh, el);
        issue(OP_MULT, a, b);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op = OP_MTHI;
        rs_data = 32'hAAAA;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, "busy_start", at);
        check("busy_start hilo", {hi, lo}, {eh, el});
        @(negedge clk);
        check("busy_start after", {62'd0, busy, done}, 64'd0);
        m_hi = eh;
        m_lo = el;

        // Asynchronous reset in the middle of an operation
        issue(is_long(OP_DIV) ? OP_DIV : OP_MULT, 32'd100, 32'd7);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        check("async reset hilo", {hi, lo}, 64'd0);
        check("async reset flags", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        run_op("multu_post_rst", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

        repeat (24) begin
            o = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            eh = m_hi;
            el = m_lo;
            model(o, a, b, eh, el);
            run_op($sformatf("rnd op%0d %h %h", o, a, b), o, a, b, eh, el);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit with its HI/LO result registers, sitting in the EX stage directly downstream of the register file. It takes the two register-file read operands (rs, rt) of MULT/MULTU/DIV/DIVU/MTHI/MTLO and produces 32-bit HI and LO values for MFHI/MFLO. It exposes a busy/done handshake so the hazard logic can stall dependent instructions.

## Interface
- ITER, 32, iterations per multiply/divide (one operand bit per cycle)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clears state and HI/LO
- start  in  1  issue strobe for op, sampled on posedge clk
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
- rs_data  in  32  operand A / dividend / MTHI-MTLO source
- rt_data  in  32  operand B / divisor
- flush  in  1  abort the in-flight operation (pipeline flush)
- busy  out  1  high while a MULT/DIV is in flight
- done  out  1  one-cycle pulse when HI/LO have just been committed
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- Reset: state IDLE, counter 0, busy=0, done=0, hi=0, lo=0. Reset takes effect mid-operation; the partial result is discarded.
- States:
  - IDLE: on start with a MULT/DIV op, latch operands, sign flags and op, then go to CALC.
  - CALC: ITER shift-add (multiply) or restoring shift-subtract (divide) steps on magnitudes. After step ITER-1, go to FIX.
  - FIX: sign correction and commit HI/LO, then go to IDLE.
- MTHI/MTLO in IDLE: hi (or lo) takes rs_data at the edge. No busy, no done.
- start while busy=1 is ignored; upstream stalls on busy.
- Undefined op codes are no-ops.
- Signed ops: operate on |rs| and |rt| (|0x80000000| = 0x80000000 unsigned).
  - Product: 64-bit result is negated if the operand signs differ.
  - Divide: quotient is negated if the signs differ; remainder takes the dividend's sign.
- Result placement:
  - MULT/MULTU: {hi,lo} = 64-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder.
- Divide by zero (signed or unsigned): lo=0xFFFFFFFF, hi=rs_data as latched.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- flush:
  - In CALC or FIX: returns to IDLE at the next edge. hi/lo unchanged, no done.
  - In IDLE together with start: flush wins and start is dropped.
  - An MTHI/MTLO that coincides with flush is dropped.

## Timing
- start accepted at edge E0. busy is high from after E0 until E33.
- CALC occupies edges E1..E32 and FIX commits at E33.
- After E33: hi/lo hold the result, busy=0, done=1 for exactly one cycle.
- A new start is accepted at E33+1 at the earliest. Back-to-back issue therefore costs 34 cycles per op.
- MTHI/MTLO: visible one edge after start.
- Outputs hi/lo/busy/done are registered. No combinational path from inputs to outputs.

## Configuration
- MDU_DIV_EN defined: DIV/DIVU are supported as above and the divider datapath is instantiated.
- MDU_DIV_EN undefined:
  - DIV/DIVU are treated as undefined no-ops: busy stays 0, no done, hi/lo unchanged.
  - Divider logic is absent; MULT/MULTU/MTHI/MTLO behaviour and timing are unchanged.

## Structure
- Shared package mdu_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO
  - state encoding: ST_IDLE, ST_CALC, ST_FIX
  - default ITER
- One sub-module, mdu_divider: restoring divide core with a per-cycle step enable and magnitude inputs. It is instantiated only under MDU_DIV_EN.
- The multiplier, sign handling, FSM and HI/LO registers stay in the top.

## Test plan
- MULT rs=0xFFFFFFFE, rt=3 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once. MULTU on the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTLO 0x1234, then MULT 5*5 with flush at CALC edge 10 -> lo stays 0x1234, busy drops next edge, no done.
- MULT issued, second start with MTHI 0xAAAA at E5 -> ignored; final hi/lo are the product only; busy low exactly at E33+.
- reset asserted mid-DIV at E20 -> hi=lo=0, busy=0 immediately. A new MULTU 3*4 after deassert -> lo=12, hi=0.
- Build without MDU_DIV_EN: DIVU 10/3 -> busy never rises, no done, hi/lo unchanged. MULT is still correct.
